// File: rtl/wishbus_pkg.sv
// rtl/wishbus_pkg.sv - shared types and constants for the wishbus copy engine
package wishbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RD_STB,
        ST_RD_WAIT,
        ST_WR_STB,
        ST_WR_WAIT,
        ST_NEXT,
        ST_FIN
    } wb_copy_state_e;

    localparam int   WB_WORD_BYTES = 2;
    localparam logic WB_WE_READ    = 1'b1;
    localparam logic WB_WE_WRITE   = 1'b0;

    // sel_i is held low (bus owned) from GRANT through WR_WAIT of each word
    function automatic logic wb_owns_bus(input wb_copy_state_e s);
        return (s == ST_GRANT) || (s == ST_RD_STB) || (s == ST_RD_WAIT) ||
               (s == ST_WR_STB) || (s == ST_WR_WAIT);
    endfunction

endpackage

// File: rtl/mem_wif_t.sv
// rtl/mem_wif_t.sv - 16-bit word bus between an initiator (dev) and a responder
interface mem_wif_t;
    logic        clk_i;
    logic        rst_i;
    logic        sel_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        cyc_o;
    logic        ack_o;

    modport dev (
        output clk_i, rst_i, sel_i, stb_i, we_i, addr_i, dat_o,
        input  dat_i, cyc_o, ack_o
    );

    modport rsp (
        input  clk_i, rst_i, sel_i, stb_i, we_i, addr_i, dat_o,
        output dat_i, cyc_o, ack_o
    );
endinterface

// File: rtl/wishbus_xfer.sv
// rtl/wishbus_xfer.sv - watches one transaction: cyc_o rise then fall, with timeout
module wishbus_xfer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic cyc,
    output logic done,
    output logic tout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          seen;

    // Counter restarts whenever the watch is idle (strobe cycle) and on the cyc rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            seen <= 1'b0;
        end else if (!active) begin
            cnt  <= '0;
            seen <= 1'b0;
        end else if (cyc && !seen) begin
            cnt  <= '0;
            seen <= 1'b1;
        end else if (cnt != CW'(TIMEOUT - 1)) begin
            cnt  <= cnt + CW'(1);
        end
    end

    assign done = active && seen && !cyc;
    assign tout = active && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wishbus_copy.sv
// rtl/wishbus_copy.sv - bus-initiator DMA: copy or fill len 16-bit words
module wishbus_copy
    import wishbus_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int TIMEOUT  = 255,
    parameter bit GRANT_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start,
    input  logic             fill,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      fill_val,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    mem_wif_t.dev            mem
);
    wb_copy_state_e   state, state_d;
    logic [31:0]      src_q, dst_q, addr_q;
    logic [LEN_W-1:0] cnt_q;
    logic [15:0]      fval_q, dat_q;
    logic             fill_q, abort_q;
    logic             sel_q, stb_q, we_q;
    logic             x_active, x_done, x_tout;
    logic             accept, timeout_fin;

    assign accept   = (state == ST_IDLE) && start;
    assign x_active = (state == ST_GRANT) || (state == ST_RD_WAIT) || (state == ST_WR_WAIT);

    wishbus_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .active (x_active),
        .cyc    (mem.cyc_o),
        .done   (x_done),
        .tout   (x_tout)
    );

    always_comb begin
        state_d     = state;
        timeout_fin = 1'b0;
        unique case (state)
            // len = 0 passes through NEXT so busy is seen for one cycle before done
            ST_IDLE:    if (start) state_d = (len == '0) ? ST_NEXT : ST_GRANT;
            ST_GRANT: begin
                if (!GRANT_EN || mem.ack_o) begin
                    state_d = fill_q ? ST_WR_STB : ST_RD_STB;
                end else if (x_tout) begin
                    state_d     = ST_FIN;
                    timeout_fin = 1'b1;
                end
            end
            ST_RD_STB:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (x_done) begin
                    state_d = ST_WR_STB;
                end else if (x_tout) begin
                    state_d     = ST_FIN;
                    timeout_fin = 1'b1;
                end
            end
            ST_WR_STB:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (x_done) begin
                    state_d = ST_NEXT;
                end else if (x_tout) begin
                    state_d     = ST_FIN;
                    timeout_fin = 1'b1;
                end
            end
            ST_NEXT:    state_d = (cnt_q <= LEN_W'(1) || abort_q) ? ST_FIN : ST_GRANT;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered yet aligned to the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            sel_q   <= 1'b1;
            stb_q   <= 1'b0;
            we_q    <= WB_WE_READ;
            addr_q  <= '0;
            dat_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fval_q  <= '0;
            fill_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != ST_IDLE) && (state_d != ST_FIN);
            done  <= (state_d == ST_FIN);
            sel_q <= !wb_owns_bus(state_d);
            stb_q <= (state_d == ST_RD_STB) || (state_d == ST_WR_STB);

            if (accept) begin
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                cnt_q   <= len;
                fill_q  <= fill;
                fval_q  <= fill_val;
                abort_q <= 1'b0;
                err     <= 1'b0;
            end else if (abort && state != ST_IDLE) begin
                abort_q <= 1'b1;
            end

            if (timeout_fin) err <= 1'b1;

            if (state == ST_NEXT) begin
                src_q <= src_q + 32'(WB_WORD_BYTES);
                dst_q <= dst_q + 32'(WB_WORD_BYTES);
                cnt_q <= cnt_q - LEN_W'(1);
            end

            if (state_d == ST_RD_STB) begin
                addr_q <= src_q;
                we_q   <= WB_WE_READ;
            end else if (state_d == ST_WR_STB) begin
                addr_q <= dst_q;
                we_q   <= WB_WE_WRITE;
                dat_q  <= fill_q ? fval_q : mem.dat_i;
            end
        end
    end

    assign mem.clk_i  = clk_i;
    assign mem.rst_i  = 1'b0;
    assign mem.sel_i  = sel_q;
    assign mem.stb_i  = stb_q;
    assign mem.we_i   = we_q;
    assign mem.addr_i = addr_q;
    assign mem.dat_o  = dat_q;

endmodule

// File: tb/tb_wishbus_copy.sv
// tb/tb_wishbus_copy.sv - self-checking bench for wishbus_copy with RAM and arbiter models
module tb_wishbus_copy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, fill, abort;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len, fill_val;
    logic        busy, done, err;

    mem_wif_t bus ();

    wishbus_copy #(.LEN_W(16), .TIMEOUT(8), .GRANT_EN(1'b1)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start    (start),
        .fill     (fill),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .fill_val (fill_val),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (bus)
    );

    int vecs = 0;
    int errs = 0;
    int cyc_no = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder: source image for reads, separate array collecting writes
    int          rsp_delay = 1, cyc_len = 2, grant_delay = 0;
    bit          no_rsp = 1'b0;
    logic [15:0] img [0:511];
    logic [15:0] ram [0:511];
    logic        pend, p_we, granted;
    int          dcnt, gcnt;
    logic [31:0] p_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cyc_o <= 1'b0;
            bus.dat_i <= 16'h0;
            pend      <= 1'b0;
            p_we      <= 1'b0;
            p_addr    <= 32'h0;
            dcnt      <= 0;
        end else if (bus.stb_i && !no_rsp) begin
            pend   <= 1'b1;
            dcnt   <= 0;
            p_addr <= bus.addr_i;
            p_we   <= bus.we_i;
            if (!bus.we_i) ram[bus.addr_i[9:1]] <= bus.dat_o;
        end else if (pend) begin
            dcnt <= dcnt + 1;
            if (dcnt == rsp_delay - 1) bus.cyc_o <= 1'b1;
            if (dcnt == rsp_delay + cyc_len - 1) begin
                bus.cyc_o <= 1'b0;
                pend      <= 1'b0;
                if (p_we) bus.dat_i <= img[p_addr[9:1]];
            end
        end
    end

    // Arbiter stand-in: another user holds the bus for grant_delay cycles before the ack pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack_o <= 1'b0;
            granted   <= 1'b0;
            gcnt      <= 0;
        end else if (bus.sel_i) begin
            bus.ack_o <= 1'b0;
            granted   <= 1'b0;
            gcnt      <= 0;
        end else if (!granted) begin
            if (gcnt == grant_delay) begin
                bus.ack_o <= 1'b1;
                granted   <= 1'b1;
            end else begin
                gcnt <= gcnt + 1;
            end
        end else begin
            bus.ack_o <= 1'b0;
        end
    end

    // Model: ordered read addresses and (address, data) writes the command must produce
    logic [31:0] exp_rd[$];
    logic [47:0] exp_wr[$];
    int          stb_cnt = 0, wr_cnt = 0, done_cnt = 0, last_stb_cyc = 0;
    logic [31:0] hold_addr = 32'h0;

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = s + 32'(2 * i);
            exp_rd.push_back(a);
            exp_wr.push_back({d + 32'(2 * i), img[a[9:1]]});
        end
    endtask

    task automatic expect_fill(input logic [31:0] d, input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) exp_wr.push_back({d + 32'(2 * i), v});
    endtask

    always @(negedge clk) begin
        logic [47:0] w;
        if (rst_n) begin
            if (bus.stb_i) begin
                stb_cnt++;
                last_stb_cyc = cyc_no;
                hold_addr    = bus.addr_i;
                check("stb_after_grant", 48'(granted), 48'(1));
                check("stb_sel_low", 48'(bus.sel_i), 48'(0));
                if (bus.we_i) begin
                    check("read_expected", 48'(exp_rd.size() != 0), 48'(1));
                    if (exp_rd.size() != 0) check("rd_addr", 48'(bus.addr_i), 48'(exp_rd.pop_front()));
                end else begin
                    wr_cnt++;
                    check("write_expected", 48'(exp_wr.size() != 0), 48'(1));
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 48'(bus.addr_i), 48'(w[47:16]));
                        check("wr_data", 48'(bus.dat_o), 48'(w[15:0]));
                    end
                end
            end
            if (bus.cyc_o) check("addr_stable", 48'(bus.addr_i), 48'(hold_addr));
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic f, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] n, input logic [15:0] v);
        fill = f; src_addr = s; dst_addr = d; len = n; fill_val = v; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            if (done) begin
                at = cyc_no;
                break;
            end
            tick();
        end
        check("done_in_budget", 48'(at != -1), 48'(1));
    endtask

    int at, d0, s0, w0;

    initial begin
        rst_n = 1'b0; start = 1'b0; fill = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
        for (int i = 0; i < 512; i++) img[i] = 16'hB000 + 16'(i);
        for (int i = 0; i < 4; i++) img[8 + i] = 16'hA001 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 48'(busy), 48'(0));
        check("rst_done", 48'(done), 48'(0));
        check("rst_err", 48'(err), 48'(0));
        check("rst_sel", 48'(bus.sel_i), 48'(1));
        check("rst_stb", 48'(bus.stb_i), 48'(0));
        check("rst_we", 48'(bus.we_i), 48'(1));
        check("rst_addr", 48'(bus.addr_i), 48'(0));
        check("rst_dat", 48'(bus.dat_o), 48'(0));
        check("rst_rst_i", 48'(bus.rst_i), 48'(0));
        rst_n = 1'b1;
        tick();

        // copy 4 words 0x10 -> 0x40
        d0 = done_cnt;
        expect_copy(32'h10, 32'h40, 4);
        issue(1'b0, 32'h10, 32'h40, 16'd4, 16'h0);
        check("copy_busy_rise", 48'(busy), 48'(1));
        wait_done(200, at);
        check("copy_busy_fall", 48'(busy), 48'(0));
        check("copy_err", 48'(err), 48'(0));
        tick(); tick();
        check("copy_ram0", 48'(ram[9'h20]), 48'h A001);
        check("copy_ram1", 48'(ram[9'h21]), 48'h A002);
        check("copy_ram2", 48'(ram[9'h22]), 48'h A003);
        check("copy_ram3", 48'(ram[9'h23]), 48'h A004);
        check("copy_one_done", 48'(done_cnt - d0), 48'(1));
        check("copy_rd_left", 48'(exp_rd.size()), 48'(0));
        check("copy_wr_left", 48'(exp_wr.size()), 48'(0));

        // fill across the 32-bit wrap
        grant_delay = 2;
        expect_fill(32'hFFFF_FFFC, 3, 16'h5A5A);
        issue(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd3, 16'h5A5A);
        wait_done(200, at);
        tick(); tick();
        check("fill_ram_fffc", 48'(ram[9'h1FE]), 48'h5A5A);
        check("fill_ram_fffe", 48'(ram[9'h1FF]), 48'h5A5A);
        check("fill_ram_0000", 48'(ram[9'h000]), 48'h5A5A);
        check("fill_wr_left", 48'(exp_wr.size()), 48'(0));

        // len = 0
        s0 = stb_cnt;
        issue(1'b0, 32'h10, 32'h50, 16'd0, 16'h0);
        check("len0_busy", 48'(busy), 48'(1));
        check("len0_no_done_yet", 48'(done), 48'(0));
        tick();
        check("len0_done", 48'(done), 48'(1));
        check("len0_busy_fall", 48'(busy), 48'(0));
        tick();
        check("len0_no_stb", 48'(stb_cnt - s0), 48'(0));

        // responder silent -> timeout
        grant_delay = 0;
        no_rsp = 1'b1;
        exp_rd.push_back(32'h10);
        w0 = wr_cnt;
        issue(1'b0, 32'h10, 32'h60, 16'd2, 16'h0);
        wait_done(40, at);
        check("tout_err", 48'(err), 48'(1));
        check("tout_latency", 48'((at - last_stb_cyc) <= 10), 48'(1));
        check("tout_sel_high", 48'(bus.sel_i), 48'(1));
        check("tout_stb_low", 48'(bus.stb_i), 48'(0));
        tick(); tick();
        check("tout_err_sticky", 48'(err), 48'(1));
        check("tout_no_write", 48'(wr_cnt - w0), 48'(0));
        no_rsp = 1'b0;
        expect_copy(32'h10, 32'h60, 1);
        issue(1'b0, 32'h10, 32'h60, 16'd1, 16'h0);
        check("err_cleared", 48'(err), 48'(0));
        wait_done(100, at);
        tick(); tick();
        check("after_tout_ram", 48'(ram[9'h30]), 48'hA001);

        // competing user holds the bus before every grant
        grant_delay = 3;
        expect_copy(32'h10, 32'h80, 2);
        issue(1'b0, 32'h10, 32'h80, 16'd2, 16'h0);
        wait_done(200, at);
        tick(); tick();
        check("grant_ram0", 48'(ram[9'h40]), 48'hA001);
        check("grant_ram1", 48'(ram[9'h41]), 48'hA002);
        check("grant_err", 48'(err), 48'(0));

        // abort during the second word's read wait
        grant_delay = 0;
        s0 = stb_cnt; w0 = wr_cnt;
        expect_copy(32'h100, 32'h300, 2);
        issue(1'b0, 32'h100, 32'h300, 16'd8, 16'h0);
        for (int i = 0; i < 100 && (stb_cnt - s0) < 3; i++) tick();
        check("abort_reached_rd2", 48'(stb_cnt - s0), 48'(3));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(100, at);
        tick(); tick();
        check("abort_two_writes", 48'(wr_cnt - w0), 48'(2));
        check("abort_ram0", 48'(ram[9'd384]), 48'hB080);
        check("abort_ram1", 48'(ram[9'd385]), 48'hB081);
        check("abort_wr_left", 48'(exp_wr.size()), 48'(0));

        // asynchronous reset in the middle of a word
        d0 = done_cnt;
        expect_copy(32'h100, 32'h340, 4);
        issue(1'b0, 32'h100, 32'h340, 16'd4, 16'h0);
        for (int i = 0; i < 50 && !bus.cyc_o; i++) tick();
        check("midrst_cyc_seen", 48'(bus.cyc_o), 48'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", 48'(bus.sel_i), 48'(1));
        check("midrst_stb", 48'(bus.stb_i), 48'(0));
        check("midrst_busy", 48'(busy), 48'(0));
        check("midrst_we", 48'(bus.we_i), 48'(1));
        exp_rd.delete();
        exp_wr.delete();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("midrst_no_done", 48'(done_cnt - d0), 48'(0));
        check("midrst_idle", 48'(busy), 48'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
